keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/calc_pkg.sv | 82 ++++++++
 rtl/keypad_scan_sync_2ff.sv | 35 +++
 rtl/keypad_scan.sv | 201 ++++++++++++++++++++
 tb/tb_keypad_scan.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator front end:
//   - 4-bit key codes produced by the keypad and consumed by calc_top.cmd
//   - the keypad scanner FSM state type
//   - keymap(): physical (row, column) position -> key code
//   - small helpers for decoding an active-low column sample
// -----------------------------------------------------------------------------
package calc_pkg;

    // Digit codes
    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;

    // Operator and control codes
    localparam logic [3:0] OP_ADD   = 4'hA;
    localparam logic [3:0] OP_SUB   = 4'hB;
    localparam logic [3:0] OP_MUL   = 4'hC;
    localparam logic [3:0] OP_D     = 4'hD;
    localparam logic [3:0] OP_EQ    = 4'hE;
    localparam logic [3:0] CMD_IDLE = 4'hF;

    // Keypad scanner states
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_e;

    // Physical key position to key code. Row 3 / column 3 maps to CMD_IDLE,
    // which is how the scanner recognises the reserved key.
    function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = KEY_1;
            4'h1:    code = KEY_2;
            4'h2:    code = KEY_3;
            4'h3:    code = OP_ADD;
            4'h4:    code = KEY_4;
            4'h5:    code = KEY_5;
            4'h6:    code = KEY_6;
            4'h7:    code = OP_SUB;
            4'h8:    code = KEY_7;
            4'h9:    code = KEY_8;
            4'hA:    code = KEY_9;
            4'hB:    code = OP_MUL;
            4'hC:    code = OP_D;
            4'hD:    code = KEY_0;
            4'hE:    code = OP_EQ;
            default: code = CMD_IDLE;
        endcase
        return code;
    endfunction

    // True when exactly one active-low column is asserted.
    function automatic logic single_low(input logic [3:0] cols_n);
        return ($countones(~cols_n) == 1);
    endfunction

    // Index of the (single) low column; only meaningful when single_low() holds.
    function automatic logic [1:0] col_index(input logic [3:0] cols_n);
        logic [1:0] idx;
        case (cols_n)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a bus of independent asynchronous level signals.
// Both stages reset to all-ones so that idle (pulled-up) lines read as
// inactive straight out of reset.
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset
//   d_i     : asynchronous input bus
//   q_o     : synchronized output bus (two clocks of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
// 4x4 matrix keypad scanner with debounce, producing one key code per press
// for calc_top.
//   clock     : system clock, rising edge
//   reset     : asynchronous active-low reset
//   col_n     : column sense lines, active-low, asynchronous to clock
//   row_n     : row drive, one-hot active-low
//   cmd       : accepted key code, 4'hF when no key is held
//   cmd_valid : one-clock pulse when a new key is accepted
//   key_held  : high from acceptance until the release has been debounced
// Parameters:
//   SCAN_CYCLES     : clocks each row is driven before its columns are sampled (>= 3)
//   DEBOUNCE_CYCLES : consecutive identical samples to accept a press or release (>= 1)
// -----------------------------------------------------------------------------
module keypad_scan
    import calc_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    output logic       key_held
);

    localparam int SCW = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 2;
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_CYCLES - 1);
    localparam logic [DBW-1:0] DEB_DONE  = DBW'(DEBOUNCE_CYCLES);

    // Synchronized column sample; the raw pins are never used directly.
    logic [3:0] col_s;

    sync_2ff #(
        .WIDTH (4)
    ) u_col_sync (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (col_n),
        .q_o    (col_s)
    );

    kp_state_e      state_q,     state_d;
    logic [1:0]     row_q,       row_d;
    logic [SCW-1:0] scan_cnt_q,  scan_cnt_d;
    logic [DBW-1:0] deb_cnt_q,   deb_cnt_d;
    logic [3:0]     pat_q,       pat_d;
    logic           reserved_q,  reserved_d;
    logic [3:0]     row_n_q,     row_n_d;
    logic [3:0]     cmd_q,       cmd_d;
    logic           cmd_valid_q, cmd_valid_d;
    logic           key_held_q,  key_held_d;

    logic [DBW-1:0] deb_inc;
    logic [3:0]     code;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        scan_cnt_d  = scan_cnt_q;
        deb_cnt_d   = deb_cnt_q;
        pat_d       = pat_q;
        reserved_d  = reserved_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        key_held_d  = key_held_q;
        deb_inc     = deb_cnt_q + DBW'(1);
        code        = keymap(row_q, col_index(pat_q));

        case (state_q)
            SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    // End of the row dwell: the column lines have settled and
                    // passed the synchronizer, so this is the one valid sample.
                    scan_cnt_d = '0;
                    if (single_low(col_s)) begin
                        state_d   = DEBOUNCE;
                        pat_d     = col_s;
                        deb_cnt_d = '0;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + SCW'(1);
                end
            end

            DEBOUNCE: begin
                if (col_s != pat_q) begin
                    // Bounce or a second key: give up on this row and move on.
                    state_d    = SCAN;
                    deb_cnt_d  = '0;
                    scan_cnt_d = '0;
                    row_d      = row_q + 2'd1;
                end else if (deb_inc == DEB_DONE) begin
                    deb_cnt_d = '0;
                    if (code == CMD_IDLE) begin
                        // Reserved key: swallow it and wait for it to be freed.
                        state_d    = RELEASE;
                        reserved_d = 1'b1;
                    end else begin
                        state_d     = PRESSED;
                        cmd_d       = code;
                        cmd_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                    end
                end else begin
                    deb_cnt_d = deb_inc;
                end
            end

            PRESSED: begin
                // Only a full release matters here; extra keys are ignored.
                // The first all-high sample already counts toward the release.
                if (col_s == 4'hF) begin
                    if (DEBOUNCE_CYCLES <= 1) begin
                        state_d    = SCAN;
                        row_d      = 2'd0;
                        scan_cnt_d = '0;
                        deb_cnt_d  = '0;
                        cmd_d      = CMD_IDLE;
                        key_held_d = 1'b0;
                        reserved_d = 1'b0;
                    end else begin
                        state_d   = RELEASE;
                        deb_cnt_d = DBW'(1);
                    end
                end
            end

            RELEASE: begin
                if (col_s != 4'hF) begin
                    // Key came back: a normal key returns to PRESSED without a
                    // new pulse; the reserved key just restarts the count.
                    deb_cnt_d = '0;
                    if (!reserved_q) begin
                        state_d = PRESSED;
                    end
                end else if (deb_inc == DEB_DONE) begin
                    state_d    = SCAN;
                    row_d      = 2'd0;
                    scan_cnt_d = '0;
                    deb_cnt_d  = '0;
                    cmd_d      = CMD_IDLE;
                    key_held_d = 1'b0;
                    reserved_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_inc;
                end
            end

            default: begin
                state_d    = SCAN;
                row_d      = 2'd0;
                scan_cnt_d = '0;
                deb_cnt_d  = '0;
            end
        endcase

        row_n_d = 4'b1111;
        row_n_d[row_d] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= SCAN;
            row_q       <= 2'd0;
            scan_cnt_q  <= '0;
            deb_cnt_q   <= '0;
            pat_q       <= 4'hF;
            reserved_q  <= 1'b0;
            row_n_q     <= 4'b1110;
            cmd_q       <= CMD_IDLE;
            cmd_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            scan_cnt_q  <= scan_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            pat_q       <= pat_d;
            reserved_q  <= reserved_d;
            row_n_q     <= row_n_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign row_n     = row_n_q;
    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan
// Keypad model drives col_n from row_n and the set of held keys; stimulus
// pushes the expected key code when it presses a key, and an independent
// monitor pops and compares on every cmd_valid pulse.
// -----------------------------------------------------------------------------
module tb_keypad_scan;

    localparam int SCAN_CYCLES     = 4;
    localparam int DEBOUNCE_CYCLES = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       key_held;

    logic [15:0] keys = '0;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          pulses   = 0;
    logic [3:0]  exp_q[$];

    // Key index = row*4 + col; code from the keypad legend.
    logic [3:0] code_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                  4'h4, 4'h5, 4'h6, 4'hB,
                                  4'h7, 4'h8, 4'h9, 4'hC,
                                  4'hD, 4'h0, 4'hE, 4'hF};

    keypad_scan #(
        .SCAN_CYCLES     (SCAN_CYCLES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .col_n     (col_n),
        .row_n     (row_n),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .key_held  (key_held)
    );

    always #5 clock = ~clock;

    // Passive matrix: a held key pulls its column low while its row is driven.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && (row_n[r] == 1'b0))
                    col_n[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [3:0] row_pat(input int r);
        logic [3:0] v;
        v = 4'b1111;
        v[r] = 1'b0;
        return v;
    endfunction

    // Scoreboard monitor
    always @(negedge clock) begin : monitor
        logic [3:0] e;
        if (reset && cmd_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_cmd_valid: actual pulse with cmd %0h, required no pulse", cmd);
            end else begin
                e = exp_q.pop_front();
                check("cmd_code", cmd, e);
                check("key_held_at_valid", key_held, 1);
            end
        end
    end

    task automatic wait_row(input logic [3:0] r);
        int n;
        n = 0;
        @(negedge clock);
        while (row_n !== r && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("wait_row", row_n, r);
    endtask

    task automatic press(input int idx, input int hold, input int gap,
                         input int nbounce, input bit rel_bounce);
        int p0;
        p0 = pulses;
        for (int b = 0; b < nbounce; b++) begin
            keys[idx] = 1'b1;
            @(negedge clock);
            keys[idx] = 1'b0;
            @(negedge clock);
        end
        if (idx != 15) exp_q.push_back(code_tab[idx]);
        keys[idx] = 1'b1;
        repeat (hold) @(negedge clock);
        check("key_held_during_hold", key_held, (idx != 15));
        if (idx != 15) check("cmd_during_hold", cmd, code_tab[idx]);
        keys[idx] = 1'b0;
        if (rel_bounce) begin
            repeat (2) @(negedge clock);
            keys[idx] = 1'b1;
            @(negedge clock);
            keys[idx] = 1'b0;
        end
        repeat (gap) @(negedge clock);
        check("pulses_per_press", pulses - p0, (idx != 15) ? 1 : 0);
        check("cmd_idle_after", cmd, 4'hF);
        check("key_held_after", key_held, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout, required end of test");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int p0;
        int seq[6];

        // Reset state and row rotation
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_row_n", row_n, 4'b1110);
        check("rst_cmd", cmd, 4'hF);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_key_held", key_held, 0);
        reset = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clock);
            check("scan_step", row_n, row_pat((i / 4) % 4));
        end

        // Clean press of row0/col1 with latency and release timing
        wait_row(row_pat(3));
        p0 = pulses;
        keys[1] = 1'b1;
        exp_q.push_back(4'h2);
        wait_row(row_pat(0));
        repeat (SCAN_CYCLES + DEBOUNCE_CYCLES - 1) @(negedge clock);
        check("latency_early", cmd_valid, 0);
        @(negedge clock);
        check("latency", cmd_valid, 1);
        repeat (30) @(negedge clock);
        check("clean_cmd", cmd, 4'h2);
        check("clean_held", key_held, 1);
        check("clean_one_pulse", pulses - p0, 1);
        keys[1] = 1'b0;
        repeat (2 + DEBOUNCE_CYCLES - 1) @(negedge clock);
        check("release_not_yet", key_held, 1);
        check("release_cmd_kept", cmd, 4'h2);
        @(negedge clock);
        check("release_held", key_held, 0);
        check("release_cmd", cmd, 4'hF);
        check("release_row0", row_n, 4'b1110);
        repeat (10) @(negedge clock);

        // Bounce during debounce on row1/col3, then a stable retry
        wait_row(row_pat(0));
        p0 = pulses;
        keys[7] = 1'b1;
        wait_row(row_pat(1));
        repeat (SCAN_CYCLES) @(negedge clock);
        keys[7] = 1'b0;
        @(negedge clock);
        keys[7] = 1'b1;
        repeat (4) @(negedge clock);
        check("bounce_no_pulse", pulses - p0, 0);
        exp_q.push_back(4'hB);
        repeat (40) @(negedge clock);
        check("bounce_retry_pulse", pulses - p0, 1);
        check("bounce_retry_cmd", cmd, 4'hB);
        keys = '0;
        repeat (20) @(negedge clock);

        // Two keys in one row are ignored
        p0 = pulses;
        keys[8]  = 1'b1;
        keys[10] = 1'b1;
        repeat (60) @(negedge clock);
        check("multi_key_ignored", pulses - p0, 0);
        check("multi_key_idle", cmd, 4'hF);
        keys = '0;
        repeat (10) @(negedge clock);

        // Extra key added while one is accepted
        p0 = pulses;
        exp_q.push_back(4'h1);
        keys[0] = 1'b1;
        repeat (40) @(negedge clock);
        check("first_key_cmd", cmd, 4'h1);
        keys[14] = 1'b1;
        repeat (20) @(negedge clock);
        check("extra_key_cmd", cmd, 4'h1);
        check("extra_key_held", key_held, 1);
        keys = '0;
        repeat (20) @(negedge clock);
        check("extra_key_pulses", pulses - p0, 1);

        // Calculator sequence 1 2 3 A 1 E, then the reserved key
        seq = '{0, 1, 2, 3, 0, 14};
        foreach (seq[i]) press(seq[i], 40, 20, 0, 1'b0);
        press(15, 40, 20, 0, 1'b0);

        // Reset while key 5 is held
        p0 = pulses;
        exp_q.push_back(4'h5);
        keys[5] = 1'b1;
        repeat (40) @(negedge clock);
        check("pre_reset_pulse", pulses - p0, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_cmd", cmd, 4'hF);
        check("async_rst_held", key_held, 0);
        check("async_rst_row", row_n, 4'b1110);
        @(negedge clock);
        repeat (2) @(negedge clock);
        exp_q.push_back(4'h5);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        check("reaccept_pulse", pulses - p0, 2);
        check("reaccept_cmd", cmd, 4'h5);
        keys = '0;
        repeat (20) @(negedge clock);

        // Random keys with optional press and release bounce
        for (int n = 0; n < 12; n++) begin
            press(int'($urandom_range(0, 15)), int'($urandom_range(40, 70)),
                  int'($urandom_range(20, 30)), int'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)));
        end

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
